quad_step_gen: RTL and testbench

Quadrature signal generator: accepts signed step commands over a valid/ready handshake and drives A/B quadrature outputs, one phase edge every `period` clocks. It is the transmit side of our rotary-encoder counter interface. It is used to emulate joint encoders in hardware-in-the-loop tests and to drive stepper-style quadrature inputs. An internal position counter tracks the emitted edges.

---
 rtl/quad_step_gen.sv | 197 +++++++++++++++++++
 tb/tb_quad_step_gen.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_step_gen.sv
// Quadrature step generator: signed step commands in, A/B quadrature edges out at a programmable spacing.
// Optional index output Z is built when QUAD_STEP_GEN_INDEX_EN is defined; otherwise Z is tied low.
module quad_step_gen #(
  parameter int unsigned STEP_W = 8,
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0]  cmd_period,
  input  logic              stop,
  output logic              A,
  output logic              B,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  position,
  output logic              Z
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_dir;
  logic [STEP_W-1:0] r_rem;
  logic [DIV_W-1:0]  r_period;
  logic [DIV_W-1:0]  r_div;
  logic [1:0]        r_phase;
  logic [CNT_W-1:0]  r_pos;
  logic              r_a;
  logic              r_b;
  logic              r_busy;
  logic              r_done;
  logic              r_ready;

  logic [STEP_W-1:0] w_abs;
  logic [DIV_W-1:0]  w_period;
  logic              w_accept;
  logic              w_step;
  logic              w_last;
  logic [1:0]        w_phase_nxt;
  logic [CNT_W-1:0]  w_pos_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_ready_nxt;

  assign w_accept = (r_state == S_IDLE) && cmd_valid;
  assign w_step   = (r_state == S_RUN) && (r_div == DIV_W'(1));
  assign w_last   = (r_rem == STEP_W'(1));

  // Magnitude is taken as unsigned so the most negative command still yields its full count.
  always_comb begin
    w_abs = cmd_steps;
    if (cmd_steps[STEP_W-1]) begin
      w_abs = ~cmd_steps + STEP_W'(1);
    end
    w_period = cmd_period;
    if (cmd_period == '0) begin
      w_period = DIV_W'(1);
    end
  end

  // Phase and position advance together on every emitted step.
  always_comb begin
    w_phase_nxt = r_phase;
    w_pos_nxt   = r_pos;
    if (w_step) begin
      if (r_dir) begin
        w_phase_nxt = r_phase - 2'd1;
        w_pos_nxt   = r_pos - CNT_W'(1);
      end else begin
        w_phase_nxt = r_phase + 2'd1;
        w_pos_nxt   = r_pos + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = (w_abs == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if ((w_step && w_last) || stop) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status flags are decoded from the next state so they can be registered without lag.
  always_comb begin
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_ready_nxt = 1'b0;
    unique case (w_state_nxt)
      S_IDLE:  w_ready_nxt = 1'b1;
      S_RUN:   w_busy_nxt  = 1'b1;
      S_FIN:   w_done_nxt  = 1'b1;
      default: w_ready_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // Command latch, edge divider and remaining-step counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dir    <= 1'b0;
      r_rem    <= '0;
      r_period <= DIV_W'(1);
      r_div    <= DIV_W'(1);
    end else if (w_accept) begin
      r_dir    <= cmd_steps[STEP_W-1];
      r_rem    <= w_abs;
      r_period <= w_period;
      r_div    <= w_period;
    end else if (r_state == S_RUN) begin
      if (w_step) begin
        r_rem <= r_rem - STEP_W'(1);
        r_div <= r_period;
      end else begin
        r_div <= r_div - DIV_W'(1);
      end
    end
  end

  // Gray-coded phase 0..3 -> AB 00,01,11,10: A is phase[1], B is phase[1]^phase[0].
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_phase <= 2'd0;
      r_pos   <= '0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      r_pos   <= w_pos_nxt;
      r_a     <= w_phase_nxt[1];
      r_b     <= w_phase_nxt[1] ^ w_phase_nxt[0];
    end
  end

`ifdef QUAD_STEP_GEN_INDEX_EN
  logic r_z;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_z <= 1'b1;
    end else begin
      r_z <= (w_pos_nxt == '0);
    end
  end

  assign Z = r_z;
`else
  assign Z = 1'b0;
`endif

  assign A         = r_a;
  assign B         = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cmd_ready = r_ready;
  assign position  = r_pos;

endmodule

// File: tb/tb_quad_step_gen.sv
// Bench for quad_step_gen: per-cycle comparison against a step-schedule model plus directed literal checks.
module tb_quad_step_gen;

  localparam int unsigned STEP_W = 8;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned CNT_W  = 5;
  localparam int          MODN   = 32;
`ifdef QUAD_STEP_GEN_INDEX_EN
  localparam int          Z_EN   = 1;
`else
  localparam int          Z_EN   = 0;
`endif

  logic              CLK;
  logic              RST_N;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [STEP_W-1:0] cmd_steps;
  logic [DIV_W-1:0]  cmd_period;
  logic              stop;
  logic              A;
  logic              B;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  position;
  logic              Z;

  int n_vec = 0;
  int n_err = 0;

  quad_step_gen #(
    .STEP_W(STEP_W),
    .DIV_W (DIV_W),
    .CNT_W (CNT_W)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_steps (cmd_steps),
    .cmd_period(cmd_period),
    .stop      (stop),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .position  (position),
    .Z         (Z)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: steps scheduled at absolute edges acc + k*P; mode 0 idle, 1 running, 2 finishing.
  int cyc    = 0;
  int m_mode = 0;
  int m_acc  = 0;
  int m_p    = 1;
  int m_n    = 0;
  int m_k    = 0;
  int m_dir  = 1;
  int m_pos  = 0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_mode = 0;
      m_pos  = 0;
    end else begin
      int s;
      bit due;
      cyc++;
      case (m_mode)
        0: if (cmd_valid) begin
          s     = $signed(cmd_steps);
          m_n   = (s < 0) ? -s : s;
          m_dir = (s < 0) ? -1 : 1;
          m_p   = (cmd_period == 0) ? 1 : int'(cmd_period);
          m_acc = cyc;
          m_k   = 0;
          m_mode = (m_n == 0) ? 2 : 1;
        end
        1: begin
          due = (cyc == m_acc + (m_k + 1) * m_p);
          if (due) begin
            m_k++;
            m_pos = (m_pos + m_dir + MODN) % MODN;
          end
          if ((due && m_k == m_n) || stop) m_mode = 2;
        end
        default: m_mode = 0;
      endcase
    end
  end

  function automatic logic [1:0] ab_of(input int pos);
    logic [1:0] tbl [4];
    tbl[0] = 2'b00;
    tbl[1] = 2'b01;
    tbl[2] = 2'b11;
    tbl[3] = 2'b10;
    return tbl[pos % 4];
  endfunction

  always @(negedge CLK) begin
    if (RST_N) begin
      logic [1:0] e_ab;
      int e_z;
      e_ab = ab_of(m_pos);
      e_z  = (Z_EN != 0 && m_pos == 0) ? 1 : 0;
      n_vec++;
      if ({A, B} !== e_ab || int'(position) != m_pos || busy !== (m_mode == 1) ||
          done !== (m_mode == 2) || cmd_ready !== (m_mode == 0) || int'(Z) != e_z) begin
        n_err++;
        $display("FAIL model cycle %0d: got AB=%b pos=%0d busy=%b done=%b rdy=%b Z=%b, required AB=%b pos=%0d busy=%0d done=%0d rdy=%0d Z=%0d",
                 cyc, {A, B}, position, busy, done, cmd_ready, Z,
                 e_ab, m_pos, m_mode == 1, m_mode == 2, m_mode == 0, e_z);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic send(input int s, input int per);
    int n;
    n = 0;
    while (!cmd_ready && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("ready_timeout", int'(n < 40), 1);
    cmd_valid  = 1'b1;
    cmd_steps  = STEP_W'(s);
    cmd_period = DIV_W'(per);
    @(negedge CLK);
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int j);
    j = 0;
    while (!done && j < limit) begin
      @(negedge CLK);
      j++;
    end
    chk("done_timeout", int'(done), 1);
  endtask

  task automatic do_reset;
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_ab", int'({A, B}), 0);
    chk("rst_pos", int'(position), 0);
    chk("rst_rdy_busy_done", int'({cmd_ready, busy, done}), 4);
    chk("rst_z", int'(Z), Z_EN);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  logic [1:0] ab_log [14];
  logic       dn_log [14];
  int         j;

  initial begin
    RST_N      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_steps  = '0;
    cmd_period = '0;
    stop       = 1'b0;
    #12;
    chk("por_ab", int'({A, B}), 0);
    chk("por_pos", int'(position), 0);
    chk("por_rdy_busy_done", int'({cmd_ready, busy, done}), 4);
    chk("por_z", int'(Z), Z_EN);
    @(negedge CLK);
    RST_N = 1'b1;

    // +4 steps, period 3: edges t+3, t+6, t+9, t+12.
    send(4, 3);
    for (int k = 0; k < 14; k++) begin
      ab_log[k] = {A, B};
      dn_log[k] = done;
      if (k == 12) chk("p4_pos", int'(position), 4);
      if (k < 13) @(negedge CLK);
    end
    chk("p4_ab2", int'(ab_log[2]), 0);
    chk("p4_ab3", int'(ab_log[3]), 1);
    chk("p4_ab5", int'(ab_log[5]), 1);
    chk("p4_ab6", int'(ab_log[6]), 3);
    chk("p4_ab9", int'(ab_log[9]), 2);
    chk("p4_ab11", int'(ab_log[11]), 2);
    chk("p4_ab12", int'(ab_log[12]), 0);
    chk("p4_done11", int'(dn_log[11]), 0);
    chk("p4_done12", int'(dn_log[12]), 1);

    // -3 steps, period 0 (as 1): wraps below zero on consecutive edges.
    do_reset();
    send(-3, 0);
    @(negedge CLK);
    chk("m3_ab1", int'({A, B}), 2);
    chk("m3_pos1", int'(position), 31);
    @(negedge CLK);
    chk("m3_ab2", int'({A, B}), 3);
    chk("m3_pos2", int'(position), 30);
    @(negedge CLK);
    chk("m3_ab3", int'({A, B}), 1);
    chk("m3_pos3", int'(position), 29);
    chk("m3_done", int'(done), 1);

    // Most negative command: 128 steps.
    do_reset();
    send(-128, 1);
    wait_done(300, j);
    chk("n128_len", j, 128);
    chk("n128_pos", int'(position), 0);
    chk("n128_z", int'(Z), Z_EN);
    @(negedge CLK);
    chk("n128_done_once", int'(done), 0);

    // +10 period 5, stop sampled at t+12: only steps at t+5, t+10.
    do_reset();
    send(10, 5);
    repeat (11) @(negedge CLK);
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    chk("stop12_done", int'(done), 1);
    chk("stop12_pos", int'(position), 2);
    chk("stop12_ab", int'({A, B}), 3);
    repeat (2) @(negedge CLK);
    chk("stop12_pos_hold", int'(position), 2);

    // Stop coinciding with the step at t+10: that step still appears.
    send(10, 5);
    repeat (9) @(negedge CLK);
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    chk("stop10_done", int'(done), 1);
    chk("stop10_pos", int'(position), 4);
    chk("stop10_ab", int'({A, B}), 0);

    // Zero-step command.
    send(0, 7);
    chk("zero_done", int'(done), 1);
    chk("zero_rdy", int'(cmd_ready), 0);
    @(negedge CLK);
    chk("zero_done_off", int'(done), 0);
    chk("zero_rdy_back", int'(cmd_ready), 1);
    chk("zero_ab", int'({A, B}), 0);

    // cmd_valid held while busy must be ignored.
    send(3, 4);
    cmd_valid = 1'b1;
    cmd_steps = STEP_W'(50);
    repeat (6) @(negedge CLK);
    cmd_valid = 1'b0;
    wait_done(40, j);
    chk("hold_pos", int'(position), 7);
    repeat (3) @(negedge CLK);
    chk("hold_pos_after", int'(position), 7);

    // Asynchronous reset mid-run at AB=11, then a fresh +1 command.
    do_reset();
    send(8, 2);
    repeat (4) @(negedge CLK);
    chk("mid_ab", int'({A, B}), 3);
    chk("mid_pos", int'(position), 2);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_ab", int'({A, B}), 0);
    chk("mid_rst_pos", int'(position), 0);
    chk("mid_rst_busy", int'(busy), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    send(1, 1);
    @(negedge CLK);
    chk("post_ab", int'({A, B}), 1);
    chk("post_done", int'(done), 1);
    chk("post_pos", int'(position), 1);
    repeat (3) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
